wb_byte_serializer: RTL and testbench

Sequential Wishbone B3 width converter between the 32-bit system interconnect and the 8-bit UART wrapper port. Each 32-bit master access is split into one classic 8-bit slave cycle per asserted byte select, issued in ascending address order. Read bytes are assembled into a 32-bit word, and the master cycle ends with a single ack, err or rty.

---
 rtl/wb_byte_serializer.sv | 179 +++++++++++++++++
 tb/tb_wb_byte_serializer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_byte_serializer.sv
// wb_byte_serializer: splits each 32-bit Wishbone master access into classic
// 8-bit slave cycles, one per selected byte, in ascending address order.
// Read bytes are gathered into a 32-bit word. The master access ends with a
// single ack, err or rty pulse.
module wb_byte_serializer #(
    parameter int AW = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    // master (32-bit) side
    input  logic [AW-1:0] wbm_adr_i,
    input  logic [31:0]   wbm_dat_i,
    input  logic [3:0]    wbm_sel_i,
    input  logic          wbm_we_i,
    input  logic          wbm_cyc_i,
    input  logic          wbm_stb_i,
    input  logic [2:0]    wbm_cti_i,
    input  logic [1:0]    wbm_bte_i,
    output logic [31:0]   wbm_dat_o,
    output logic          wbm_ack_o,
    output logic          wbm_err_o,
    output logic          wbm_rty_o,
    // slave (8-bit) side
    output logic [AW-1:0] wbs_adr_o,
    output logic [7:0]    wbs_dat_o,
    output logic          wbs_we_o,
    output logic          wbs_cyc_o,
    output logic          wbs_stb_o,
    output logic [2:0]    wbs_cti_o,
    output logic [1:0]    wbs_bte_o,
    input  logic [7:0]    wbs_dat_i,
    input  logic          wbs_ack_i,
    input  logic          wbs_err_i,
    input  logic          wbs_rty_i
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    localparam logic [1:0] ST_ACK = 2'd0;
    localparam logic [1:0] ST_ERR = 2'd1;
    localparam logic [1:0] ST_RTY = 2'd2;

    state_t        state_q, state_d;
    logic [AW-3:0] adr_q, adr_d;
    logic [31:0]   wdat_q, wdat_d;
    logic [3:0]    sel_q, sel_d;
    logic          we_q, we_d;
    logic [1:0]    off_q, off_d;
    logic [31:0]   rdat_q, rdat_d;
    logic [1:0]    stat_q, stat_d;

    logic [1:0]    first_off;
    logic [1:0]    next_off;
    logic          next_found;
    logic [4:0]    lane_base;

    // Cycle type, burst type and the byte bits of the word address have no
    // effect: every master beat is served as a classic single access.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, wbm_cti_i, wbm_bte_i, wbm_adr_i[1:0]};

    // Offset k is selected by sel[3-k]; offset 0 lives in bits [31:24].
    assign lane_base = {~off_q, 3'b000};

    // Find the lowest selected offset of a new request and the next selected
    // offset after the current one (scanning downward keeps the smallest).
    always_comb begin
        first_off  = 2'd0;
        next_off   = off_q;
        next_found = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (wbm_sel_i[3-k]) begin
                first_off = 2'(k);
            end
            if ((k > int'(off_q)) && sel_q[3-k]) begin
                next_off   = 2'(k);
                next_found = 1'b1;
            end
        end
    end

    // Next-state logic: latch request, walk the selected bytes, terminate.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        off_d   = off_q;
        rdat_d  = rdat_q;
        stat_d  = stat_q;
        case (state_q)
            IDLE: begin
                if (wbm_cyc_i && wbm_stb_i) begin
                    adr_d  = wbm_adr_i[AW-1:2];
                    wdat_d = wbm_dat_i;
                    sel_d  = wbm_sel_i;
                    we_d   = wbm_we_i;
                    // Writes leave the last read word visible.
                    if (!wbm_we_i) begin
                        rdat_d = 32'h0;
                    end
                    if (wbm_sel_i == 4'h0) begin
                        stat_d  = ST_ACK;
                        state_d = DONE;
                    end else begin
                        off_d   = first_off;
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                if (!wbm_cyc_i) begin
                    // Master gave up: drop the slave cycle silently.
                    state_d = IDLE;
                end else if (wbs_err_i) begin
                    stat_d  = ST_ERR;
                    state_d = DONE;
                end else if (wbs_rty_i) begin
                    stat_d  = ST_RTY;
                    state_d = DONE;
                end else if (wbs_ack_i) begin
                    if (!we_q) begin
                        rdat_d[lane_base +: 8] = wbs_dat_i;
                    end
                    if (next_found) begin
                        off_d = next_off;
                    end else begin
                        stat_d  = ST_ACK;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            wdat_q  <= 32'h0;
            sel_q   <= 4'h0;
            we_q    <= 1'b0;
            off_q   <= 2'd0;
            rdat_q  <= 32'h0;
            stat_q  <= ST_ACK;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            off_q   <= off_d;
            rdat_q  <= rdat_d;
            stat_q  <= stat_d;
        end
    end

    assign wbs_cyc_o = (state_q == BUS);
    assign wbs_stb_o = (state_q == BUS);
    assign wbs_we_o  = (state_q == BUS) && we_q;
    assign wbs_adr_o = {adr_q, off_q};
    assign wbs_dat_o = wdat_q[lane_base +: 8];
    assign wbs_cti_o = 3'b000;
    assign wbs_bte_o = 2'b00;

    assign wbm_dat_o = rdat_q;
    assign wbm_ack_o = (state_q == DONE) && (stat_q == ST_ACK);
    assign wbm_err_o = (state_q == DONE) && (stat_q == ST_ERR);
    assign wbm_rty_o = (state_q == DONE) && (stat_q == ST_RTY);

endmodule

// File: tb/tb_wb_byte_serializer.sv
// Directed bench for wb_byte_serializer: a zero-wait slave model with
// programmable err/rty/stall behaviour and a per-access beat log.
module tb_wb_byte_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wbm_adr_i;
    logic [31:0] wbm_dat_i;
    logic [3:0]  wbm_sel_i;
    logic        wbm_we_i, wbm_cyc_i, wbm_stb_i;
    logic [2:0]  wbm_cti_i;
    logic [1:0]  wbm_bte_i;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [31:0] wbs_adr_o;
    logic [7:0]  wbs_dat_o;
    logic        wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [2:0]  wbs_cti_o;
    logic [1:0]  wbs_bte_o;
    logic [7:0]  wbs_dat_i;
    logic        wbs_ack_i, wbs_err_i, wbs_rty_i;

    // slave model controls
    logic        slave_hold;
    int          err_idx, rty_idx;
    logic [7:0]  rd_mem [4];
    int          beat_cnt;
    logic [31:0] log_adr [8];
    logic [7:0]  log_dat [8];
    logic        log_we  [8];
    int          n_ack, n_err, n_rty;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_byte_serializer #(.AW(32)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbm_adr_i (wbm_adr_i),
        .wbm_dat_i (wbm_dat_i),
        .wbm_sel_i (wbm_sel_i),
        .wbm_we_i  (wbm_we_i),
        .wbm_cyc_i (wbm_cyc_i),
        .wbm_stb_i (wbm_stb_i),
        .wbm_cti_i (wbm_cti_i),
        .wbm_bte_i (wbm_bte_i),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_o (wbm_ack_o),
        .wbm_err_o (wbm_err_o),
        .wbm_rty_o (wbm_rty_o),
        .wbs_adr_o (wbs_adr_o),
        .wbs_dat_o (wbs_dat_o),
        .wbs_we_o  (wbs_we_o),
        .wbs_cyc_o (wbs_cyc_o),
        .wbs_stb_o (wbs_stb_o),
        .wbs_cti_o (wbs_cti_o),
        .wbs_bte_o (wbs_bte_o),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_i (wbs_ack_i),
        .wbs_err_i (wbs_err_i),
        .wbs_rty_i (wbs_rty_i)
    );

    // Zero-wait slave: terminates in the same cycle it sees stb.
    logic slave_act;
    assign slave_act = wbs_cyc_o && wbs_stb_o && !slave_hold;
    assign wbs_err_i = slave_act && (beat_cnt == err_idx);
    assign wbs_rty_i = slave_act && (beat_cnt == rty_idx);
    assign wbs_ack_i = slave_act && (beat_cnt != err_idx) && (beat_cnt != rty_idx);
    assign wbs_dat_i = rd_mem[wbs_adr_o[1:0]];

    // Beat log (cleared whenever a new master request waits in front of an
    // idle slave bus) and termination pulse counters.
    always @(posedge clk) begin
        if (wbm_ack_o) n_ack <= n_ack + 1;
        if (wbm_err_o) n_err <= n_err + 1;
        if (wbm_rty_o) n_rty <= n_rty + 1;
        if (!wbs_cyc_o && wbm_cyc_i && wbm_stb_i) begin
            beat_cnt <= 0;
        end else if (slave_act && (wbs_ack_i || wbs_err_i || wbs_rty_i) && beat_cnt < 8) begin
            log_adr[beat_cnt] <= wbs_adr_o;
            log_dat[beat_cnt] <= wbs_dat_o;
            log_we[beat_cnt]  <= wbs_we_o;
            beat_cnt          <= beat_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // One master access; returns cycles from the sampling edge to the
    // termination and the termination as {ack,err,rty}.
    task automatic master_access(input logic [31:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input logic we,
                                 output int cyc, output logic [2:0] term);
        wbm_adr_i = adr;
        wbm_dat_i = dat;
        wbm_sel_i = sel;
        wbm_we_i  = we;
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
        cyc  = -1;
        term = 3'b000;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (wbm_ack_o || wbm_err_o || wbm_rty_o) begin
                term = {wbm_ack_o, wbm_err_o, wbm_rty_o};
                cyc  = i;
                break;
            end
        end
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        $display("access adr=%h sel=%b we=%0d -> cycles=%0d term=%b beats=%0d",
                 adr, sel, we, cyc, term, beat_cnt);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    int          cyc;
    logic [2:0]  term;
    int          a0, e0, r0;

    initial begin
        rst = 1'b1;
        wbm_adr_i = 32'h0; wbm_dat_i = 32'h0; wbm_sel_i = 4'h0;
        wbm_we_i = 1'b0; wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
        wbm_cti_i = 3'b010; wbm_bte_i = 2'b00;
        slave_hold = 1'b0; err_idx = -1; rty_idx = -1;
        rd_mem[0] = 8'h12; rd_mem[1] = 8'hA5; rd_mem[2] = 8'h5A; rd_mem[3] = 8'h34;
        beat_cnt = 0; n_ack = 0; n_err = 0; n_rty = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dat_o", wbm_dat_o, 32'h0);
        check("rst_cyc_stb", {wbs_cyc_o, wbs_stb_o, wbs_we_o}, 3'b000);
        check("rst_terms", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 3'b000);
        check("rst_adr_o", wbs_adr_o, 32'h0);
        check("rst_cti_bte", {wbs_cti_o, wbs_bte_o}, 5'b0);
        rst = 1'b0;
        idle_cycle();

        // Read byte at offset 1
        master_access(32'h9000_0004, 32'h0, 4'b0100, 1'b0, cyc, term);
        check("rdb_cycles", cyc, 2);
        check("rdb_term", term, 3'b100);
        check("rdb_beats", beat_cnt, 1);
        check("rdb_adr", log_adr[0], 32'h9000_0005);
        check("rdb_we", log_we[0], 1'b0);
        check("rdb_data", wbm_dat_o, 32'h00A5_0000);
        idle_cycle();
        check("rdb_single_pulse", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 3'b000);

        // Write word: four contiguous bytes
        master_access(32'h9000_0000, 32'h1122_3344, 4'hF, 1'b1, cyc, term);
        check("wr_cycles", cyc, 5);
        check("wr_term", term, 3'b100);
        check("wr_beats", beat_cnt, 4);
        check("wr_b0", {log_adr[0], log_dat[0], 7'd0, log_we[0]}, {32'h9000_0000, 8'h11, 8'h01});
        check("wr_b1", {log_adr[1], log_dat[1], 7'd0, log_we[1]}, {32'h9000_0001, 8'h22, 8'h01});
        check("wr_b2", {log_adr[2], log_dat[2], 7'd0, log_we[2]}, {32'h9000_0002, 8'h33, 8'h01});
        check("wr_b3", {log_adr[3], log_dat[3], 7'd0, log_we[3]}, {32'h9000_0003, 8'h44, 8'h01});
        check("wr_keeps_rdata", wbm_dat_o, 32'h00A5_0000);
        idle_cycle();
        check("wr_single_pulse", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 3'b000);

        // Sparse read: offsets 0 and 3
        master_access(32'h9000_0008, 32'h0, 4'b1001, 1'b0, cyc, term);
        check("sparse_cycles", cyc, 3);
        check("sparse_beats", beat_cnt, 2);
        check("sparse_adr", {log_adr[0], log_adr[1]}, {32'h9000_0008, 32'h9000_000B});
        check("sparse_data", wbm_dat_o, 32'h1200_0034);
        idle_cycle();

        // Error on second byte
        a0 = n_ack; e0 = n_err;
        err_idx = 1;
        master_access(32'h9000_0000, 32'hDEAD_BEEF, 4'hF, 1'b1, cyc, term);
        check("err_cycles", cyc, 3);
        check("err_term", term, 3'b010);
        check("err_beats", beat_cnt, 2);
        idle_cycle();
        check("err_pulse_count", {n_ack - a0, n_err - e0}, {32'd0, 32'd1});
        err_idx = -1;

        // Retry on third byte
        rty_idx = 2;
        master_access(32'h9000_0000, 32'h0, 4'hF, 1'b0, cyc, term);
        check("rty_cycles", cyc, 4);
        check("rty_term", term, 3'b001);
        rty_idx = -1;
        idle_cycle();

        // err and rty together: err wins
        err_idx = 0; rty_idx = 0;
        master_access(32'h9000_0000, 32'h0, 4'hF, 1'b0, cyc, term);
        check("prio_term", term, 3'b010);
        check("prio_cycles", cyc, 2);
        err_idx = -1; rty_idx = -1;
        idle_cycle();

        // sel == 0: no slave cycle
        master_access(32'h9000_0010, 32'h0, 4'h0, 1'b0, cyc, term);
        check("sel0_cycles", cyc, 1);
        check("sel0_term", term, 3'b100);
        check("sel0_beats", beat_cnt, 0);
        idle_cycle();

        // Master abort while the slave stalls
        a0 = n_ack; e0 = n_err; r0 = n_rty;
        slave_hold = 1'b1;
        wbm_adr_i = 32'h9000_0000; wbm_sel_i = 4'hF; wbm_we_i = 1'b0;
        wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
        idle_cycle(); idle_cycle();
        check("abort_busy", {wbs_cyc_o, wbs_stb_o}, 2'b11);
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
        idle_cycle();
        check("abort_drop", {wbs_cyc_o, wbs_stb_o}, 2'b00);
        repeat (3) idle_cycle();
        check("abort_no_term", {n_ack - a0, n_err - e0, n_rty - r0}, 96'd0);

        // Reset in the middle of a transfer
        wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
        idle_cycle(); idle_cycle();
        check("rstmid_busy", wbs_cyc_o, 1'b1);
        rst = 1'b1;
        idle_cycle();
        check("rstmid_outs", {wbs_cyc_o, wbs_stb_o, wbs_we_o, wbm_ack_o, wbm_err_o, wbm_rty_o}, 6'b0);
        check("rstmid_dat_adr", {wbm_dat_o, wbs_adr_o}, 64'h0);
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
        rst = 1'b0; slave_hold = 1'b0;
        idle_cycle();

        // Back-to-back reads: second request raised right after the ack
        master_access(32'h9000_0000, 32'h0, 4'b0010, 1'b0, cyc, term);
        check("b2b1_cycles", cyc, 2);
        check("b2b1_data", wbm_dat_o, 32'h0000_5A00);
        master_access(32'h9000_0000, 32'h0, 4'b1100, 1'b0, cyc, term);
        check("b2b2_cycles", cyc, 4);
        check("b2b2_term", term, 3'b100);
        check("b2b2_data", wbm_dat_o, 32'h12A5_0000);
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
